mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter that drives the 2-bit `SEL` input of the team's 4:1 two-bit multiplexer. It takes four request lines, one per mux input (A=0, B=1, C=2, D=3), grants one requester at a time, and holds `SEL` stable for the whole grant. A grant ends on consumer release, on request withdrawal, or on a programmable hold timeout. It sits directly upstream of the mux select and gives the mux a registered, glitch-free select.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant may stay in BUSY; 0 disables the timeout. Legal range 0–255.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to `CLK` at system level.
- `REQ` in 4: request vector; bit i requests mux input i.
- `DONE` in 1: consumer release; sampled only in BUSY.
- `SEL` out 2: registered select to the mux; binary index of the current or last grant.
- `GRANT` out 4: registered one-hot grant; all zero when idle.
- `VALID` out 1: registered; high while a grant is active (BUSY).
- `TIMEOUT` out 1: registered one-cycle pulse when a grant ends by hold timeout.

## Operation
- Reset values: `SEL`=2'b00, `GRANT`=4'b0000, `VALID`=0, `TIMEOUT`=0. Internal pointer `PTR`=0, hold counter=0, state=IDLE.
- States: IDLE and BUSY.
- **IDLE behaviour:**
  - If `REQ`≠0, search from index `PTR` upward, wrapping 3→0. The first set bit is the winner.
  - On the next edge: `SEL`=winner, `GRANT`=1<<winner, `VALID`=1, counter=0, state goes to BUSY.
  - If `REQ`=0: stay in IDLE. `SEL` holds its last value; `GRANT`=0, `VALID`=0.
- **BUSY behaviour:** `SEL` and `GRANT` do not change. The counter increments every BUSY cycle and saturates at 255. The release condition, evaluated each cycle, is any of:
  - `DONE`=1
  - `REQ[SEL]`=0
  - `HOLD_MAX`≠0 and counter==`HOLD_MAX`-1
- **On release, at the next edge:**
  - `VALID`=0, `GRANT`=0, state goes to IDLE.
  - `PTR`=`SEL`+1 modulo 4, so 3 wraps to 0.
  - `SEL` is unchanged.
  - `TIMEOUT`=1 for exactly one cycle only if the timeout was the sole release cause.
- **Simultaneous events:**
  - `DONE` together with the timeout condition: normal release, `TIMEOUT` stays 0.
  - Withdrawal of `REQ[SEL]` together with the timeout condition: also no `TIMEOUT`.
- **Fairness:** a released requester has the lowest priority for the next grant. All 4 requesters held high are granted in the order 0,1,2,3,0,…
- Changes to non-granted `REQ` bits during BUSY are ignored.
- Asserting `RST_N` in any state, including mid-grant, forces all reset values asynchronously. The first arbitration after reset starts from index 0.

## Timing
- Grant latency: `REQ` first sampled high at edge n gives `VALID`/`GRANT`/`SEL` updated after edge n. This means 1 cycle from request to grant.
- Release latency: a release condition sampled at edge m gives `VALID`=0 after edge m.
- There is always at least one IDLE cycle between consecutive grants. With continuous requests the minimum grant period is (BUSY cycles + 1).
- With `HOLD_MAX`=N≠0 and no other release, BUSY lasts exactly N cycles. `TIMEOUT` is high in the following IDLE cycle.
- `SEL` changes only on the IDLE→BUSY edge, so the mux select is stable for the whole grant.
- All outputs come directly from flops; there are no combinational paths from input to output.

## Test plan
- **Reset, then single request:** reset, then hold `REQ`=4'b0100.
  - Required: after 1 edge, `SEL`=2, `GRANT`=4'b0100, `VALID`=1.
  - Then pulse `DONE`: `VALID`=0 on the next edge and `PTR`=3.
- **Round-robin rotation:** hold `REQ`=4'b1111 and pulse `DONE` on the second BUSY cycle of each grant.
  - Required: grants in order `SEL`=0,1,2,3,0, with one IDLE cycle between each.
- **Timeout:** `HOLD_MAX`=4, `REQ`=4'b0001, `DONE`=0.
  - Required: `VALID` high for exactly 4 cycles, then `TIMEOUT`=1 for exactly 1 cycle.
  - The next grant goes to index 0 again, since it is the only requester.
- **Simultaneous DONE and timeout:** `HOLD_MAX`=3, with `DONE` asserted on the 3rd BUSY cycle.
  - Required: release occurs and `TIMEOUT` stays 0.
- **Withdrawal and wrap:** `REQ`=4'b1001 while `PTR`=3, so index 3 is granted. Drop `REQ[3]`.
  - Required: release on the next edge, then grant `SEL`=0, `GRANT`=4'b0001.
- **Reset mid-grant:** assert `RST_N`=0 asynchronously while in BUSY with `SEL`=2.
  - Required: `SEL`=0, `GRANT`=0, `VALID`=0 immediately, without waiting for a clock.
  - After release, `REQ`=4'b1111 is granted to index 0.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
// mux_sel_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that produces the 2-bit select for the 4:1 two-bit
// multiplexer. Four requesters (A=0, B=1, C=2, D=3) compete. One requester is
// granted at a time, and the select is held stable for the whole grant. A
// grant ends when one of three things happens: the consumer releases it, the
// request is withdrawn, or an optional hold timeout expires. Every output
// comes straight from a flop, so the mux select is glitch-free.
//
// Parameters:
//   HOLD_MAX  maximum number of BUSY cycles per grant (0 disables, 0..255)
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   4  request vector, bit i asks for mux input i
//   done      in   1  consumer release, only looked at while BUSY
//   sel       out  2  registered mux select (current or last grant)
//   grant     out  4  registered one-hot grant, zero while idle
//   valid     out  1  registered, high while a grant is active
//   timeout   out  1  one-cycle pulse when a grant ended purely by timeout
// ============================================================================
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_next;
    logic [1:0] sel_next;
    logic [3:0] grant_next;
    logic       valid_next;
    logic       timeout_next;

    logic [7:0] req_twice;
    logic [3:0] req_rot;
    logic [1:0] offset;
    logic [1:0] winner;

    logic       done_rel;
    logic       withdraw_rel;
    logic       hold_rel;
    logic       release_hit;

    // Rotate the request vector so that the pointer position lands at bit 0.
    // The first set bit of the rotated vector, added back onto the pointer,
    // gives the round-robin winner. The 2-bit add wraps 3 -> 0 on its own.
    always_comb begin
        req_twice = {req, req};
        req_rot   = 4'(req_twice >> ptr);
        offset    = 2'd3;
        if (req_rot[0]) begin
            offset = 2'd0;
        end else if (req_rot[1]) begin
            offset = 2'd1;
        end else if (req_rot[2]) begin
            offset = 2'd2;
        end
        winner = ptr + offset;
    end

    // Release causes while BUSY. They are kept separate so that the timeout
    // pulse fires only when the hold limit was the one and only cause.
    always_comb begin
        done_rel     = done;
        withdraw_rel = ~req[sel];
        hold_rel     = HOLD_EN && (hold_cnt == HOLD_LAST);
        release_hit  = done_rel | withdraw_rel | hold_rel;
    end

    // Next-state and next-output logic. Every output register has its next
    // value computed here, so the outputs stay pure flops. sel moves only on
    // the IDLE -> BUSY transition, which keeps it stable for the whole grant.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        hold_cnt_next = hold_cnt;
        sel_next      = sel;
        grant_next    = grant;
        valid_next    = valid;
        timeout_next  = 1'b0;

        unique case (state)
            IDLE: begin
                grant_next = 4'b0000;
                valid_next = 1'b0;
                if (req != 4'b0000) begin
                    state_next    = BUSY;
                    sel_next      = winner;
                    grant_next    = 4'b0001 << winner;
                    valid_next    = 1'b1;
                    hold_cnt_next = 8'd0;
                end
            end
            BUSY: begin
                hold_cnt_next = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                if (release_hit) begin
                    state_next   = IDLE;
                    grant_next   = 4'b0000;
                    valid_next   = 1'b0;
                    ptr_next     = sel + 2'd1;
                    timeout_next = hold_rel & ~done_rel & ~withdraw_rel;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, even in
    // the middle of a grant. This makes the first arbitration after reset
    // start again from index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            sel      <= 2'd0;
            grant    <= 4'b0000;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_cnt_next;
            sel      <= sel_next;
            grant    <= grant_next;
            valid    <= valid_next;
            timeout  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
// tb_mux_sel_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mux_sel_arbiter. Instance a uses HOLD_MAX=4 and covers
// reset, single requests, rotation, timeout, withdrawal and mid-grant reset.
// Instance b uses HOLD_MAX=3 and covers a release by done that coincides with
// the hold limit, plus a plain timeout at that depth.
// ============================================================================
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a;
    logic       done_a;
    logic [3:0] req_b;
    logic       done_b;
    logic [1:0] sel_a;
    logic [3:0] grant_a;
    logic       valid_a;
    logic       timeout_a;
    logic [1:0] sel_b;
    logic [3:0] grant_b;
    logic       valid_b;
    logic       timeout_b;

    int checks;
    int errors;

    mux_sel_arbiter #(.HOLD_MAX(4)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_a),
        .done    (done_a),
        .sel     (sel_a),
        .grant   (grant_a),
        .valid   (valid_a),
        .timeout (timeout_a)
    );

    mux_sel_arbiter #(.HOLD_MAX(3)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_b),
        .done    (done_b),
        .sel     (sel_b),
        .grant   (grant_b),
        .valid   (valid_b),
        .timeout (timeout_b)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs for instance a, then let one rising edge
    // pass. Sampling happens 1 ns after that edge.
    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req_a  = r;
        done_a = d;
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs of one instance against expected values.
    task automatic checkOutput(input string tag, input bit use_b,
                               input logic [1:0] exp_sel, input logic [3:0] exp_grant,
                               input logic exp_valid, input logic exp_timeout);
        logic [1:0] o_sel;
        logic [3:0] o_grant;
        logic       o_valid;
        logic       o_timeout;
        o_sel     = use_b ? sel_b     : sel_a;
        o_grant   = use_b ? grant_b   : grant_a;
        o_valid   = use_b ? valid_b   : valid_a;
        o_timeout = use_b ? timeout_b : timeout_a;
        checks++;
        assert (o_sel === exp_sel) else begin
            errors++;
            $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, o_sel, exp_sel);
        end
        checks++;
        assert (o_grant === exp_grant) else begin
            errors++;
            $error("[TB] FAIL %s grant: observed %b expected %b", tag, o_grant, exp_grant);
        end
        checks++;
        assert (o_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s valid: observed %b expected %b", tag, o_valid, exp_valid);
        end
        checks++;
        assert (o_timeout === exp_timeout) else begin
            errors++;
            $error("[TB] FAIL %s timeout: observed %b expected %b", tag, o_timeout, exp_timeout);
        end
    endtask

    // Directed sequence. Expected values are worked out by hand from the
    // round-robin pointer and the hold counter.
    initial begin
        logic [1:0] rr_sel;
        logic [3:0] rr_grant;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req_a  = 4'b0000;
        done_a = 1'b0;
        req_b  = 4'b0000;
        done_b = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("reset_a", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("reset_b", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single request on C, then a release by done. ptr becomes 3.
        applyStimulus(4'b0100, 1'b0);
        checkOutput("single_grant", 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_release", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("ptr_after_c", 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("ptr_after_c_rel", 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0);

        // Rotation with all four requesting. Done arrives on the second BUSY
        // cycle. ptr is 0 here, so the expected order is 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            rr_sel   = 2'(k % 4);
            rr_grant = 4'b0001 << rr_sel;
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("rr%0d_grant", k), 1'b0, rr_sel, rr_grant, 1'b1, 1'b0);
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("rr%0d_busy", k), 1'b0, rr_sel, rr_grant, 1'b1, 1'b0);
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("rr%0d_idle", k), 1'b0, rr_sel, 4'b0000, 1'b0, 1'b0);
        end

        // Timeout with HOLD_MAX=4. ptr is 1, and only A requests.
        applyStimulus(4'b0001, 1'b0);
        checkOutput("to_grant", 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput($sformatf("to_busy%0d", k), 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput("to_pulse", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("to_regrant", 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("to_regrant_rel", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // Move ptr to 3 through a grant on C. Then request A and D together:
        // D wins, withdrawing D releases it, and A is granted after the wrap.
        applyStimulus(4'b0100, 1'b0);
        checkOutput("wd_prep_grant", 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("wd_prep_rel", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("wd_grant_d", 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("wd_release", 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("wd_wrap_a", 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);

        // Withdrawal that coincides with the hold limit must not pulse timeout.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput($sformatf("wdto_busy%0d", k), 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wdto_release", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // Reset in the middle of a grant on C clears outputs with no clock.
        applyStimulus(4'b0100, 1'b0);
        checkOutput("mid_grant", 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_async", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        req_a = 4'b1111;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("post_reset_grant", 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("post_reset_rel", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // Instance b, HOLD_MAX=3: done on the third BUSY cycle coincides
        // with the hold limit and must not pulse timeout.
        req_b  = 4'b0001;
        done_b = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_grant", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_busy1", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_busy2", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        done_b = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_done_and_hold", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);

        // Instance b regrants A, and this time the hold limit alone ends it.
        done_b = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_regrant", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_busy_last", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("b_timeout", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
